dr_reg: RTL
===========

Name: dr_reg

Overview:
- Parametrised multi-bit JTAG data register; successor to the single-bit boundary-scan DR cell.
- One WIDTH-bit master (capture/shift) stage and one WIDTH-bit slave (update) stage.
- Adds a selectable shift direction, a shift-bit counter with overflow flag, and an update strobe for downstream logic.
- Sits between the TAP controller (which drives dr_clock/dr_shift/dr_upd) and the core-side parallel data path.

Parameters:
- WIDTH, 8: register length in bits (>=2).
- LSB_FIRST, 1: 1 = shifts toward bit 0, seri enters MSB, sero = master[0]; 0 = mirror (seri enters bit 0, sero = master[WIDTH-1]).
- UPD_RST, 0: reset value of the slave (update) stage, WIDTH bits.
- CNT_W, $clog2(WIDTH)+1: width of the shift counter.

Ports:
- tck  in  1  clock; all state changes on rising edge.
- trst  in  1  reset, synchronous, active-high.
- dr_shift  in  1  0 = master loads datai on dr_clock; 1 = master shifts seri on dr_clock.
- dr_clock  in  1  master-stage enable (capture or shift).
- dr_upd  in  1  slave-stage enable; copies master to slave.
- mode  in  1  0 = datao follows datai (functional); 1 = datao driven from slave (test).
- datai  in  WIDTH  parallel data from core / pins.
- seri  in  1  serial in (TDI side).
- datao  out  WIDTH  parallel data out.
- sero  out  1  serial out (TDO side).
- upd_stb  out  1  one-cycle pulse, cycle after a slave update.
- shift_cnt  out  CNT_W  shifts since the last capture, saturating.
- shift_ovf  out  1  sticky: more than WIDTH shifts since the last capture.

Behaviour:
- Clock is tck; reset is synchronous, active-high, named trst.
- Reset (trst=1 at a rising edge) overrides all other inputs:
  - master=0, slave=UPD_RST.
  - shift_cnt=0, shift_ovf=0, upd_stb=0.
  - Reset asserted mid-shift or mid-update discards the operation in progress.
- Master stage, rising edge, dr_clock=1:
  - dr_shift=0: master<=datai (capture); shift_cnt<=0; shift_ovf<=0.
  - dr_shift=1, LSB_FIRST=1: master<={seri, master[WIDTH-1:1]}.
  - dr_shift=1, LSB_FIRST=0: master<={master[WIDTH-2:0], seri}.
  - Each shift increments shift_cnt, saturating at 2^CNT_W-1. shift_ovf<=1 when shift_cnt==WIDTH at the time of the shift (i.e. the (WIDTH+1)th shift).
  - dr_clock=0: master, shift_cnt and shift_ovf hold.
- sero:
  - Combinational from master: master[0] if LSB_FIRST=1, else master[WIDTH-1].
  - A capture is visible on sero after the same edge (1-cycle latency).
- Slave stage, rising edge, dr_upd=1: slave<=master (the pre-edge value). upd_stb<=1 on that edge, 0 on every other edge.
- dr_upd=1 held N cycles: slave reloads each cycle and upd_stb is high N cycles.
- dr_clock=1 and dr_upd=1 in the same cycle: both act; slave takes the old master value and master takes the new capture/shift value.
- datao:
  - Combinational mux: mode=0 -> datai; mode=1 -> slave.
  - Changing mode never alters slave or master.
- Under reset, datao = datai (mode=0) or UPD_RST (mode=1); sero=0.
- Exactly WIDTH shifts with no overflow moves the full serial pattern into the master; data shifted out on sero is the previously captured value, first bit first.

Test Plan:
- WIDTH=8, LSB_FIRST=1. trst high 2 cycles, mode=1 -> datao=0x00, sero=0, shift_cnt=0, upd_stb=0.
- datai=0xA5, dr_shift=0, dr_clock=1 for 1 cycle -> sero=1. Then dr_shift=1, seri=0, 8 shifts -> sero sequence 1,0,1,0,0,1,0,1 (first value already present after capture), master=0x00, shift_cnt=8, shift_ovf=0.
- Continue a 9th shift -> shift_ovf=1, shift_cnt=9. New capture -> shift_cnt=0, shift_ovf=0.
- Shift in 0x3C LSB first, then dr_upd=1 for 1 cycle -> slave=0x3C, upd_stb high exactly the next cycle. mode=1 -> datao=0x3C; mode=0 with datai=0x55 -> datao=0x55.
- Master=0x3C, same cycle capture datai=0xFF and dr_upd=1 -> slave=0x3C, master=0xFF.
- LSB_FIRST=0, UPD_RST=0x81: after reset with mode=1 -> datao=0x81. Capture 0x80 -> sero=1. trst asserted after 3 of 8 shifts -> master=0, slave=0x81, shift_cnt=0.

Source files
------------

// File: rtl/dr_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dr_reg
//  Purpose  : Parametrised JTAG data register with capture/shift master stage,
//             update slave stage, shift counter/overflow and update strobe.
//  Revision : 1.0  initial release
// ============================================================================
module dr_reg #(
    parameter int                WIDTH     = 8,
    parameter logic              LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0]  UPD_RST   = '0,
    parameter int                CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             tck,
    input  logic             trst,
    input  logic             dr_shift,
    input  logic             dr_clock,
    input  logic             dr_upd,
    input  logic             mode,
    input  logic [WIDTH-1:0] datai,
    input  logic             seri,
    output logic [WIDTH-1:0] datao,
    output logic             sero,
    output logic             upd_stb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             shift_ovf
);

    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_width = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_master_q, w_master_d;
    logic [WIDTH-1:0] r_slave_q,  w_slave_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic             r_ovf_q,    w_ovf_d;
    logic             r_stb_q,    w_stb_d;
    logic [WIDTH-1:0] w_shifted;

    // Shift direction selects both the serial entry point and the tap feeding sero.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {seri, r_master_q[WIDTH-1:1]};
            assign sero      = r_master_q[0];
        end else begin : g_msb_first
            assign w_shifted = {r_master_q[WIDTH-2:0], seri};
            assign sero      = r_master_q[WIDTH-1];
        end
    endgenerate

    always_comb begin
        w_master_d = r_master_q;
        w_cnt_d    = r_cnt_q;
        w_ovf_d    = r_ovf_q;
        w_slave_d  = r_slave_q;
        w_stb_d    = dr_upd;
        if (dr_clock) begin
            if (!dr_shift) begin
                w_master_d = datai;
                w_cnt_d    = '0;
                w_ovf_d    = 1'b0;
            end else begin
                w_master_d = w_shifted;
                if (r_cnt_q != c_cnt_max) begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
                // Flag the shift that goes one past the register length.
                if (r_cnt_q == c_cnt_width) begin
                    w_ovf_d = 1'b1;
                end
            end
        end
        if (dr_upd) begin
            w_slave_d = r_master_q;
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            r_master_q <= '0;
            r_slave_q  <= UPD_RST;
            r_cnt_q    <= '0;
            r_ovf_q    <= 1'b0;
            r_stb_q    <= 1'b0;
        end else begin
            r_master_q <= w_master_d;
            r_slave_q  <= w_slave_d;
            r_cnt_q    <= w_cnt_d;
            r_ovf_q    <= w_ovf_d;
            r_stb_q    <= w_stb_d;
        end
    end

    assign datao     = mode ? r_slave_q : datai;
    assign upd_stb   = r_stb_q;
    assign shift_cnt = r_cnt_q;
    assign shift_ovf = r_ovf_q;

endmodule
`default_nettype wire
